// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg: FSM states, ISA encodings and ALU codes shared by the   |
// | 16-bit controller and its instruction decoder.                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOVI  = 3'd0,
    CLS_MOVR  = 3'd1,
    CLS_ADD   = 3'd2,
    CLS_CMP   = 3'd3,
    CLS_AND   = 3'd4,
    CLS_MVN   = 3'd5,
    CLS_UNDEF = 3'd6
  } instr_cls_t;

  localparam logic [2:0] OPC_MOV     = 3'b110;
  localparam logic [2:0] OPC_ALU     = 3'b101;

  localparam logic [1:0] OP_MOV_IMM  = 2'b10;
  localparam logic [1:0] OP_MOV_REG  = 2'b00;
  localparam logic [1:0] OP_ADD      = 2'b00;
  localparam logic [1:0] OP_CMP      = 2'b01;
  localparam logic [1:0] OP_AND      = 2'b10;
  localparam logic [1:0] OP_MVN      = 2'b11;

  localparam logic [1:0] ALU_ADD     = 2'b00;
  localparam logic [1:0] ALU_SUB     = 2'b01;
  localparam logic [1:0] ALU_AND     = 2'b10;
  localparam logic [1:0] ALU_NOTB    = 2'b11;

  function automatic instr_cls_t classify(input logic [2:0] opcode, input logic [1:0] op);
    instr_cls_t c;
    c = CLS_UNDEF;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      c = CLS_MOVI;
      else if (op == OP_MOV_REG) c = CLS_MOVR;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  c = CLS_ADD;
        OP_CMP:  c = CLS_CMP;
        OP_AND:  c = CLS_AND;
        default: c = CLS_MVN;
      endcase
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_controller_instr_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_decoder: splits the instruction register into its fields,  |
// | classifies it and sign-extends imm8 to the datapath width.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       i_ir,
  output instr_cls_t        o_cls,
  output logic [2:0]        o_rn,
  output logic [2:0]        o_rd,
  output logic [2:0]        o_rm,
  output logic [1:0]        o_sh,
  output logic [DATA_W-1:0] o_imm
);

  logic [2:0] w_opcode;
  logic [1:0] w_op;

  assign w_opcode = i_ir[15:13];
  assign w_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_imm    = {{(DATA_W-8){i_ir[7]}}, i_ir[7:0]};
  assign o_cls    = classify(w_opcode, w_op);

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_controller: Moore control FSM driving the 16-bit datapath.   |
// | CTRL_ILLEGAL_EN: undefined instructions trap into HALT.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic [15:0]       in,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] imm_out,
  output logic              illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  instr_cls_t  w_cls;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [2:0]  w_rm;
  logic [1:0]  w_sh;

  instr_decoder #(
    .DATA_W (DATA_W)
  ) u_dec (
    .i_ir  (r_ir),
    .o_cls (w_cls),
    .o_rn  (w_rn),
    .o_rd  (w_rd),
    .o_rm  (w_rm),
    .o_sh  (w_sh),
    .o_imm (imm_out)
  );

  // IR only loads on an accepted start, so it holds the instruction for its whole run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT && s) begin
        r_ir <= in;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;

    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) begin
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_cls)
          CLS_MOVI:                   w_next = S_WRITE_IMM;
          CLS_MOVR, CLS_MVN:          w_next = S_GET_B;
          CLS_ADD, CLS_AND, CLS_CMP:  w_next = S_GET_A;
`ifdef CTRL_ILLEGAL_EN
          default:                    w_next = S_HALT;
`else
          default:                    w_next = S_WAIT;
`endif
        endcase
      end

      S_WRITE_IMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = w_rn;
        w_next   = S_WAIT;
      end

      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = S_GET_B;
      end

      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next  = S_ALU;
      end

      S_ALU: begin
        shift  = w_sh;
        w_next = S_WRITE_REG;
        case (w_cls)
          CLS_MOVR: begin
            asel  = 1'b1;
            ALUop = ALU_ADD;
            loadc = 1'b1;
          end
          CLS_AND: begin
            ALUop = ALU_AND;
            loadc = 1'b1;
          end
          CLS_MVN: begin
            ALUop = ALU_NOTB;
            loadc = 1'b1;
          end
          // CMP only updates status; the result is never written back.
          CLS_CMP: begin
            ALUop  = ALU_SUB;
            loads  = 1'b1;
            w_next = S_WAIT;
          end
          default: begin
            ALUop = ALU_ADD;
            loadc = 1'b1;
          end
        endcase
      end

      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = w_rd;
        w_next   = S_WAIT;
      end

`ifdef CTRL_ILLEGAL_EN
      S_HALT: begin
        w_next = S_HALT;
      end
`endif

      default: begin
        w_next = S_WAIT;
      end
    endcase
  end

`ifdef CTRL_ILLEGAL_EN
  assign illegal = (r_state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cpu_controller: directed cycle-by-cycle bench with a queue of |
// | expected control vectors for cpu_controller.                     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] imm;
    logic        illegal;
  } ctrl_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic [15:0] tb_in = '0;

  logic        w, write, vsel, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] imm_out;

  ctrl_t obs;
  assign obs = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop, imm_out, illegal};

  int    checks = 0;
  int    failures = 0;
  ctrl_t q_exp[$];
  string q_tag[$];

  cpu_controller #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .s(s), .in(tb_in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
    .imm_out(imm_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t base(input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    c.imm = {{8{ir[7]}}, ir[7:0]};
    return c;
  endfunction

  function automatic ctrl_t e_wait(input logic [15:0] ir);
    ctrl_t c; c = base(ir); c.w = 1'b1; return c;
  endfunction

  function automatic ctrl_t e_wimm(input logic [15:0] ir);
    ctrl_t c; c = base(ir); c.write = 1'b1; c.vsel = 1'b1; c.writenum = ir[10:8]; return c;
  endfunction

  function automatic ctrl_t e_geta(input logic [15:0] ir);
    ctrl_t c; c = base(ir); c.readnum = ir[10:8]; c.loada = 1'b1; return c;
  endfunction

  function automatic ctrl_t e_getb(input logic [15:0] ir);
    ctrl_t c; c = base(ir); c.readnum = ir[2:0]; c.loadb = 1'b1; return c;
  endfunction

  function automatic ctrl_t e_alu(input logic [15:0] ir, input logic as, input logic [1:0] op,
                                  input logic lc, input logic ls);
    ctrl_t c; c = base(ir);
    c.shift = ir[4:3]; c.asel = as; c.aluop = op; c.loadc = lc; c.loads = ls;
    return c;
  endfunction

  function automatic ctrl_t e_wreg(input logic [15:0] ir);
    ctrl_t c; c = base(ir); c.write = 1'b1; c.writenum = ir[7:5]; return c;
  endfunction

  function automatic ctrl_t e_halt(input logic [15:0] ir);
    ctrl_t c; c = base(ir); c.illegal = 1'b1; return c;
  endfunction

  // Drive inputs for one cycle, queue what the outputs must show after the edge, then compare.
  task automatic step(input logic s_v, input logic [15:0] in_v, input logic rst_v,
                      input ctrl_t e, input string tag);
    ctrl_t got, want;
    string t;
    s = s_v; tb_in = in_v; reset = rst_v;
    q_exp.push_back(e);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    got  = obs;
    want = q_exp.pop_front();
    t    = q_tag.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", t, got, want);
    end
  endtask

  task automatic undef_seq(input logic [15:0] ir);
    step(1, ir, 0, base(ir), "undef_dec");
`ifdef CTRL_ILLEGAL_EN
    step(0, 16'h0, 0, e_halt(ir), "halt_enter");
    step(1, 16'hD007, 0, e_halt(ir), "halt_s_ignored");
    step(0, 16'h0, 0, e_halt(ir), "halt_hold");
    step(1, 16'hD007, 0, e_halt(ir), "halt_s_ignored2");
    step(0, 16'h0, 1, e_wait(16'h0), "halt_reset");
    step(0, 16'h0, 0, e_wait(16'h0), "halt_post_reset");
`else
    step(0, 16'h0, 0, e_wait(ir), "undef_done");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(0, 16'h0000, 1, e_wait(16'h0), "reset0");
    step(0, 16'h0000, 1, e_wait(16'h0), "reset1");
    step(0, 16'hD007, 0, e_wait(16'h0), "idle_no_start");

    // MOV R0,#7
    step(1, 16'hD007, 0, base(16'hD007),   "movi7_dec");
    step(0, 16'h0000, 0, e_wimm(16'hD007), "movi7_write");
    step(0, 16'h0000, 0, e_wait(16'hD007), "movi7_done");

    // MOV R1,#-2
    step(1, 16'hD1FE, 0, base(16'hD1FE),   "movim2_dec");
    step(0, 16'h0000, 0, e_wimm(16'hD1FE), "movim2_write");
    step(0, 16'h0000, 0, e_wait(16'hD1FE), "movim2_done");

    // ADD R2,R1,R0,LSL#1 with s held high and a different word on in
    step(1, 16'hA148, 0, base(16'hA148),                  "add_dec");
    step(1, 16'hA900, 0, e_geta(16'hA148),                "add_geta");
    step(1, 16'hA900, 0, e_getb(16'hA148),                "add_getb");
    step(1, 16'hA900, 0, e_alu(16'hA148, 0, 2'b00, 1, 0), "add_alu");
    step(1, 16'hA900, 0, e_wreg(16'hA148),                "add_wreg");
    step(1, 16'hA900, 0, e_wait(16'hA148),                "add_done");

    // CMP R1,R0 accepted back-to-back
    step(1, 16'hA900, 0, base(16'hA900),                  "cmp_dec");
    step(0, 16'h0000, 0, e_geta(16'hA900),                "cmp_geta");
    step(0, 16'h0000, 0, e_getb(16'hA900),                "cmp_getb");
    step(0, 16'h0000, 0, e_alu(16'hA900, 0, 2'b01, 0, 1), "cmp_alu");
    step(0, 16'h0000, 0, e_wait(16'hA900),                "cmp_done");

    // MOV R5,R1
    step(1, 16'hC0A1, 0, base(16'hC0A1),                  "movr_dec");
    step(0, 16'h0000, 0, e_getb(16'hC0A1),                "movr_getb");
    step(0, 16'h0000, 0, e_alu(16'hC0A1, 1, 2'b00, 1, 0), "movr_alu");
    step(0, 16'h0000, 0, e_wreg(16'hC0A1),                "movr_wreg");
    step(0, 16'h0000, 0, e_wait(16'hC0A1),                "movr_done");

    // AND R4,R3,R2,sh=10
    step(1, 16'hB392, 0, base(16'hB392),                  "and_dec");
    step(0, 16'h0000, 0, e_geta(16'hB392),                "and_geta");
    step(0, 16'h0000, 0, e_getb(16'hB392),                "and_getb");
    step(0, 16'h0000, 0, e_alu(16'hB392, 0, 2'b10, 1, 0), "and_alu");
    step(0, 16'h0000, 0, e_wreg(16'hB392),                "and_wreg");
    step(0, 16'h0000, 0, e_wait(16'hB392),                "and_done");

    // MVN R3,R0 aborted by reset in the ALU state
    step(1, 16'hB860, 0, base(16'hB860),                  "mvn_dec");
    step(0, 16'h0000, 0, e_getb(16'hB860),                "mvn_getb");
    step(0, 16'h0000, 0, e_alu(16'hB860, 0, 2'b11, 1, 0), "mvn_alu");
    step(0, 16'h0000, 1, e_wait(16'h0000),                "mvn_abort");
    step(0, 16'h0000, 0, e_wait(16'h0000),                "mvn_post_abort");
    step(0, 16'h0000, 0, e_wait(16'h0000),                "mvn_no_write");

    undef_seq(16'hC800);
    undef_seq(16'hE000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
